// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low keypad and emits debounced hex key codes.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 50
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);
    localparam int DIV_W  = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam int MAX_P  = DEBOUNCE_SCANS > REPEAT_SCANS ? DEBOUNCE_SCANS : REPEAT_SCANS;
    localparam int CNT_W  = $clog2(MAX_P + 1);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} stateType;

    stateType         state, stateNext;
    logic [DIV_W-1:0] divCount;
    logic             tick, scanDone;
    logic [3:0]       rowMeta, rowSync;
    logic [1:0]       colIdx, rowIdx;
    logic             colHit, scanHit, resHit;
    logic [3:0]       scanCode, colCode, resCode;
    logic [3:0]       cand, candNext, codeNext;
    logic [CNT_W-1:0] cnt, cntNext, cntInc;
    logic             validNext;
`ifdef KEYPAD_REPEAT_EN
    logic [CNT_W-1:0] repCnt, repNext, repInc;
`endif

    assign tick     = divCount == DIV_W'(SCAN_DIV - 1);
    assign scanDone = tick && colIdx == 2'd3;
    assign col_n    = ~(4'b0001 << colIdx);
    assign colHit   = ~&rowSync;
    assign rowIdx   = !rowSync[0] ? 2'd0 : !rowSync[1] ? 2'd1 : !rowSync[2] ? 2'd2 : 2'd3;
    assign colCode  = {rowIdx, colIdx};
    assign resHit   = scanHit | colHit;
    assign resCode  = scanHit ? scanCode : colCode;
    assign cntInc   = &cnt ? cnt : cnt + 1'b1;
    assign key_held = state == PRESSED || state == RELEASE;
`ifdef KEYPAD_REPEAT_EN
    assign repInc   = &repCnt ? repCnt : repCnt + 1'b1;
`endif

    // Prescaler producing one tick per column dwell
    always_ff @(posedge clock or posedge reset)
        if (reset) divCount <= '0;
        else       divCount <= tick ? '0 : divCount + 1'b1;

    // Two-flop synchronizer on the asynchronous row inputs
    always_ff @(posedge clock or posedge reset)
        if (reset) {rowSync, rowMeta} <= 8'hFF;
        else       {rowSync, rowMeta} <= {rowMeta, row_n};

    // Column rotation and first-hit capture within the current scan
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            colIdx   <= 2'd0;
            scanHit  <= 1'b0;
            scanCode <= 4'd0;
        end else if (tick) begin
            colIdx   <= colIdx + 1'b1;
            scanHit  <= colIdx == 2'd3 ? 1'b0 : resHit;
            scanCode <= colIdx == 2'd3 ? 4'd0 : resCode;
        end

    // Debounce FSM state and datapath registers
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state     <= IDLE;
            cand      <= 4'd0;
            cnt       <= '0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            repCnt    <= '0;
`endif
        end else begin
            state     <= stateNext;
            cand      <= candNext;
            cnt       <= cntNext;
            key_code  <= codeNext;
            key_valid <= validNext;
`ifdef KEYPAD_REPEAT_EN
            repCnt    <= repNext;
`endif
        end

    // Next-state logic, evaluated only when a full scan completes
    always_comb begin
        stateNext = state;
        candNext  = cand;
        cntNext   = cnt;
        codeNext  = key_code;
        validNext = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        repNext   = repCnt;
`endif
        if (scanDone)
            case (state)
                IDLE:
                    if (resHit) begin
                        candNext = resCode;
                        if (DEBOUNCE_SCANS <= 1) begin
                            stateNext = PRESSED;
                            codeNext  = resCode;
                            validNext = 1'b1;
                            cntNext   = '0;
`ifdef KEYPAD_REPEAT_EN
                            repNext   = '0;
`endif
                        end else begin
                            stateNext = DEBOUNCE;
                            cntNext   = CNT_W'(1);
                        end
                    end
                DEBOUNCE:
                    if (!resHit) begin
                        stateNext = IDLE;
                        cntNext   = '0;
                    end else if (resCode != cand) begin
                        candNext = resCode;
                        cntNext  = CNT_W'(1);
                    end else if (cntInc >= CNT_W'(DEBOUNCE_SCANS)) begin
                        stateNext = PRESSED;
                        codeNext  = cand;
                        validNext = 1'b1;
                        cntNext   = '0;
`ifdef KEYPAD_REPEAT_EN
                        repNext   = '0;
`endif
                    end else
                        cntNext = cntInc;
                PRESSED:
                    if (!resHit) begin
                        stateNext = DEBOUNCE_SCANS <= 1 ? IDLE : RELEASE;
                        cntNext   = DEBOUNCE_SCANS <= 1 ? '0 : CNT_W'(1);
`ifdef KEYPAD_REPEAT_EN
                        repNext   = '0;
                    end else if (repInc >= CNT_W'(REPEAT_SCANS)) begin
                        validNext = 1'b1;
                        repNext   = '0;
                    end else
                        repNext = repInc;
`else
                    end
`endif
                RELEASE:
                    if (resHit) begin
                        stateNext = PRESSED;
                        cntNext   = '0;
`ifdef KEYPAD_REPEAT_EN
                        repNext   = '0;
`endif
                    end else if (cntInc >= CNT_W'(DEBOUNCE_SCANS)) begin
                        stateNext = IDLE;
                        cntNext   = '0;
                    end else
                        cntNext = cntInc;
                default: stateNext = IDLE;
            endcase
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: scoreboard bench for keypad_scanner with a modelled key matrix.
module tb_keypad_scanner;
    localparam int SD = 4;
    localparam int DS = 2;
    localparam int RS = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  row_n, col_n, key_code;
    logic        key_valid, key_held;
    logic [15:0] keys;
    logic [3:0]  expCol;
    logic [3:0]  sbQ[$];
    int          checks = 0;
    int          errors = 0;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS), .REPEAT_SCANS(RS)) dut (
        .clock(clock), .reset(reset), .row_n(row_n), .col_n(col_n),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
    );

    always #5 clock = ~clock;

    // Key matrix: a pressed key pulls its row low while its column is driven low
    always_comb begin
        row_n = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic scans(input int n);
        repeat (16 * n) @(negedge clock);
    endtask

    // Every strobe must match the oldest expected key code
    always @(negedge clock)
        if (key_valid === 1'b1) begin
            check("strobe_expected", sbQ.size() != 0, 1);
            if (sbQ.size() != 0) check("strobe_code", key_code, sbQ.pop_front());
        end

    initial begin
        keys  = 16'h0;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_col", col_n, 4'b1110);
        check("rst_code", key_code, 4'h0);
        check("rst_valid", key_valid, 1'b0);
        check("rst_held", key_held, 1'b0);
        reset = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clock);
            expCol = 4'b1111 ^ (4'b0001 << ((k / 4) % 4));
            check("col_rot", col_n, expCol);
        end
        check("idle_held", key_held, 1'b0);

        keys = 16'h1 << 9;
        sbQ.push_back(4'h9);
        scans(3);
        check("t2_code", key_code, 4'h9);
        check("t2_held", key_held, 1'b1);
        keys = 16'h0;
        scans(1);
        check("t2_held_release", key_held, 1'b1);
        scans(1);
        check("t2_released", key_held, 1'b0);

        repeat (3) begin
            keys = 16'h1 << 3;
            scans(1);
            keys = 16'h0;
            scans(1);
        end
        check("t3_bounce_code", key_code, 4'h9);
        check("t3_bounce_held", key_held, 1'b0);
        keys = 16'h1 << 3;
        sbQ.push_back(4'h3);
        scans(2);
        check("t3_code", key_code, 4'h3);
        check("t3_held", key_held, 1'b1);
        keys = 16'h0;
        scans(2);
        check("t3_released", key_held, 1'b0);

        keys = (16'h1 << 4) | (16'h1 << 14);
        sbQ.push_back(4'h4);
        scans(2);
        check("t4_code", key_code, 4'h4);
        keys = keys | 16'h1;
        scans(2);
        check("t4_no_rollover", key_code, 4'h4);
        check("t4_held", key_held, 1'b1);
        keys = 16'h0;
        scans(2);
        check("t4_released", key_held, 1'b0);

        keys = 16'h1 << 5;
        scans(1);
        repeat (5) @(negedge clock);
        reset = 1'b1;
        #1;
        check("t5_col", col_n, 4'b1110);
        check("t5_code", key_code, 4'h0);
        check("t5_valid", key_valid, 1'b0);
        check("t5_held", key_held, 1'b0);
        keys = 16'h0;
        @(negedge clock);
        reset = 1'b0;
        scans(3);
        check("t5_after_code", key_code, 4'h0);
        check("t5_after_held", key_held, 1'b0);

        keys = 16'h1 << 15;
        sbQ.push_back(4'hF);
`ifdef KEYPAD_REPEAT_EN
        sbQ.push_back(4'hF);
        sbQ.push_back(4'hF);
`endif
        scans(8);
        check("t6_code", key_code, 4'hF);
        check("t6_held", key_held, 1'b1);
        keys = 16'h0;
        scans(2);
        check("t6_released", key_held, 1'b0);
        scans(1);
        check("sb_drained", sbQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
